// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: load/store codes, buffer entry type and the sub-word
// extraction used when a load is served straight from a buffered word.
package store_buffer_pkg;

  // Load/store codes; values track the shared define.vh.
  localparam logic [5:0] ALU_LB  = 6'd22;
  localparam logic [5:0] ALU_LH  = 6'd23;
  localparam logic [5:0] ALU_LW  = 6'd24;
  localparam logic [5:0] ALU_LBU = 6'd25;
  localparam logic [5:0] ALU_LHU = 6'd26;
  localparam logic [5:0] ALU_SB  = 6'd27;
  localparam logic [5:0] ALU_SH  = 6'd28;
  localparam logic [5:0] ALU_SW  = 6'd29;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  alucode;
  } sb_entry_t;

  function automatic logic is_load_code(input logic [5:0] code);
    return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
           (code == ALU_LBU) || (code == ALU_LHU);
  endfunction

  // Pick the byte/half addressed by the load out of a full stored word and
  // sign- or zero-extend it the same way data_memory would.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [5:0]  code);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (code)
      ALU_LB:  return {{24{b[7]}}, b};
      ALU_LBU: return {24'h0, b};
      ALU_LH:  return {{16{h[15]}}, h};
      ALU_LHU: return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// store_buf_match: word-granular compare of a load address against every
// buffered entry, plus a youngest-first select among the hits.
module store_buf_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][29:0] entry_word_i,
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [PTR_W-1:0]       head_i,
  input  logic [29:0]            ld_word_i,
  output logic                   match_o,
  output logic [PTR_W-1:0]       youngest_idx_o,
  output logic [DEPTH-1:0]       hit_o
);

  logic [PTR_W-1:0] scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit_o[gi] = valid_i[gi] && (entry_word_i[gi] == ld_word_i);
    end
  endgenerate

  // Walk entries oldest to youngest starting at head; the last hit seen wins.
  always_comb begin
    match_o        = 1'b0;
    youngest_idx_o = '0;
    scan_idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_i + PTR_W'(k);
      if (hit_o[scan_idx]) begin
        match_o        = 1'b1;
        youngest_idx_o = scan_idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between MEM and data_memory. Stores are
// queued, then drained one per cycle whenever the load path leaves the memory
// port free. Loads that overlap a pending word stall, unless the build defines
// STORE_BUF_FWD_EN, in which case a load hitting a full-word store is served
// from the buffer.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [5:0]  st_alucode,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [5:0]  ld_alucode,
  output logic        ld_stall,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic        mem_is_store,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [5:0]  mem_alucode,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [5:0]       code_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q;

  logic                   push, pop;
  logic [DEPTH-1:0][29:0] entry_word;
  logic [DEPTH-1:0]       hit_vec;
  logic                   match;
  logic [PTR_W-1:0]       youngest_idx;
  logic                   unused_ok;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      assign entry_word[gi] = addr_q[gi][31:2];
    end
  endgenerate

  store_buf_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entry_word_i   (entry_word),
    .valid_i        (valid_q),
    .head_i         (head_q),
    .ld_word_i      (ld_addr[31:2]),
    .match_o        (match),
    .youngest_idx_o (youngest_idx),
    .hit_o          (hit_vec)
  );

`ifdef STORE_BUF_FWD_EN
  // A full buffer still stalls (it must drain), so forwarding is only offered
  // when the load is actually allowed to complete this cycle.
  assign fwd_valid = ld_valid && !full_q && match &&
                     (code_q[youngest_idx] == ALU_SW) && is_load_code(ld_alucode);
  assign fwd_data  = fwd_valid ?
                     load_extract(data_q[youngest_idx], ld_addr[1:0], ld_alucode) : 32'h0;
  assign unused_ok = ^hit_vec;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = 32'h0;
  assign unused_ok = ^{hit_vec, youngest_idx, ld_alucode, ld_addr[1:0]};
`endif

  // Full forces a drain even under a load, so loads cannot starve stores.
  assign ld_stall     = ld_valid && (full_q || (match && !fwd_valid));
  assign mem_is_store = !empty_q && (!ld_valid || ld_stall);
  assign mem_addr     = empty_q ? 32'h0 : addr_q[head_q];
  assign mem_data     = empty_q ? 32'h0 : data_q[head_q];
  assign mem_alucode  = empty_q ? 6'h0  : code_q[head_q];

  assign st_ready = !full_q;
  assign empty    = empty_q;
  assign push     = st_valid && !full_q;
  assign pop      = mem_is_store;

  // Next pointer/count/valid state from this cycle's push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; empty/full are kept as flops so st_ready and empty are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
    end
  end

  // Entry payload; contents are only observed through valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      code_q[tail_q] <= st_alucode;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic, checked against
// a queue-based reference model. The bench also plays data_memory.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0, st_ready;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [5:0]  st_alucode = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [5:0]  ld_alucode = '0;
  logic        ld_stall, fwd_valid, mem_is_store, empty;
  logic [31:0] fwd_data, mem_addr, mem_data;
  logic [5:0]  mem_alucode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  code;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] dmem [logic [29:0]];
  logic [31:0] drained_addr[$];
  bit          allow_overlap = 1'b0;

  logic        act_ready, act_empty, act_stall, act_fwd, act_mis;
  logic [31:0] act_fwd_data, act_maddr, act_mdata;
  logic [5:0]  act_mcode;
  logic        exp_ready, exp_empty, exp_stall, exp_fwd, exp_mis;
  logic [31:0] exp_fwd_data, exp_maddr, exp_mdata;
  logic [5:0]  exp_mcode;
  logic        ld_done;
  logic [31:0] ld_result;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_alucode   (st_alucode),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_alucode   (ld_alucode),
    .ld_stall     (ld_stall),
    .fwd_valid    (fwd_valid),
    .fwd_data     (fwd_data),
    .mem_is_store (mem_is_store),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_alucode  (mem_alucode),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  // One MEM stage: a store and a load together is a protocol error, except
  // where a scenario deliberately holds the port busy to fill the buffer.
  always @(posedge clk) begin
    if (rst_n && !allow_overlap)
      assert (!(st_valid && ld_valid)) else $error("protocol: st_valid and ld_valid together");
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] tb_extract(input logic [31:0] w, input logic [1:0] off,
                                             input logic [5:0] c);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    if (c == ALU_LB)  return (b >= 32'h80)   ? b - 32'h100   : b;
    if (c == ALU_LBU) return b;
    if (c == ALU_LH)  return (h >= 32'h8000) ? h - 32'h10000 : h;
    if (c == ALU_LHU) return h;
    return w;
  endfunction

  function automatic logic [31:0] dmem_word(input logic [29:0] wi);
    if (dmem.exists(wi)) return dmem[wi];
    return 32'h0;
  endfunction

  function automatic logic [31:0] dmem_load(input logic [31:0] a, input logic [5:0] c);
    return tb_extract(dmem_word(a[31:2]), a[1:0], c);
  endfunction

  task automatic dmem_store(input logic [31:0] a, input logic [31:0] d, input logic [5:0] c);
    logic [31:0] w;
    w = dmem_word(a[31:2]);
    if (c == ALU_SB)      w[8 * a[1:0] +: 8] = d[7:0];
    else if (c == ALU_SH) w[16 * a[1] +: 16] = d[15:0];
    else                  w = d;
    dmem[a[31:2]] = w;
  endtask

  // Expected outputs from the pending-store queue and the current load.
  task automatic model_eval(input logic lv, input logic [31:0] la, input logic [5:0] lc);
    bit   found;
    bit   full;
    ent_t y;
    found = 1'b0;
    y     = '{32'h0, 32'h0, 6'h0};
    full  = (model_q.size() == DEPTH);
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (!found && model_q[i].addr[31:2] == la[31:2]) begin
        found = 1'b1;
        y     = model_q[i];
      end
    end
    exp_fwd      = 1'b0;
    exp_fwd_data = 32'h0;
`ifdef STORE_BUF_FWD_EN
    if (lv && found && !full && y.code == ALU_SW) begin
      exp_fwd      = 1'b1;
      exp_fwd_data = tb_extract(y.data, la[1:0], lc);
    end
`else
    if (y.code == 6'h3F) exp_fwd_data = 32'h0;
`endif
    exp_ready = !full;
    exp_empty = (model_q.size() == 0);
    exp_stall = lv && (full || (found && !exp_fwd));
    exp_mis   = !exp_empty && (!lv || exp_stall);
    exp_maddr = exp_empty ? 32'h0 : model_q[0].addr;
    exp_mdata = exp_empty ? 32'h0 : model_q[0].data;
    exp_mcode = exp_empty ? 6'h0  : model_q[0].code;
  endtask

  // Drive one cycle, snapshot outputs mid-cycle, then advance model and memory.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [5:0] sc, input logic lv, input logic [31:0] la,
                      input logic [5:0] lc, input bit ovl);
    ent_t e;
    @(negedge clk);
    allow_overlap = ovl;
    st_valid = sv; st_addr = sa; st_data = sd; st_alucode = sc;
    ld_valid = lv; ld_addr = la; ld_alucode = lc;
    #1;
    act_ready = st_ready;  act_empty = empty;   act_stall = ld_stall;
    act_fwd = fwd_valid;   act_fwd_data = fwd_data; act_mis = mem_is_store;
    act_maddr = mem_addr;  act_mdata = mem_data; act_mcode = mem_alucode;
    model_eval(lv, la, lc);
    ld_done   = lv && !act_stall;
    ld_result = act_fwd ? act_fwd_data : dmem_load(la, lc);
    @(posedge clk);
    if (act_mis) begin
      dmem_store(act_maddr, act_mdata, act_mcode);
      drained_addr.push_back(act_maddr);
    end
    if (exp_mis && model_q.size() > 0) model_q.delete(0);
    if (sv && exp_ready) begin
      e.addr = sa; e.data = sd; e.code = sc;
      model_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 32'h0, 6'h0, 1'b0);
  endtask

  task automatic drain_idle(input string tag);
    int n;
    n = 0;
    while ((model_q.size() != 0 || empty !== 1'b1) && n < 16) begin
      idle();
      n++;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain empty=%b required 1 after %0d cycles", tag, empty, n);
    end
  endtask

  task automatic test_reset();
    ld_valid = 1'b1; ld_addr = 32'h100; ld_alucode = ALU_LW;
    @(negedge clk); #1;
    checks++;
    if ({st_ready, empty, mem_is_store, ld_stall, fwd_valid} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags got %b required 11000", {st_ready, empty, mem_is_store, ld_stall, fwd_valid});
    end
    checks++;
    if ({fwd_data, mem_addr, mem_data, mem_alucode} !== 102'h0) begin
      errors++;
      $display("FAIL reset_data fwd=%h addr=%h data=%h code=%h required all 0", fwd_data, mem_addr, mem_data, mem_alucode);
    end
    $display("reset: st_ready=%b empty=%b", st_ready, empty);
    ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_drain();
    step(1'b1, 32'h100, 32'h11223344, ALU_SW, 1'b0, 32'h0, 6'h0, 1'b0);
    idle();
    checks++;
    if ({act_mis, act_maddr, act_mdata, act_mcode} !== {1'b1, 32'h100, 32'h11223344, ALU_SW}) begin
      errors++;
      $display("FAIL single_drain mis=%b addr=%h data=%h code=%h required 1 00000100 11223344 %h",
               act_mis, act_maddr, act_mdata, act_mcode, ALU_SW);
    end
    idle();
    checks++;
    if ({act_empty, act_mis} !== 2'b10) begin
      errors++;
      $display("FAIL single_empty empty=%b mis=%b required 1 0", act_empty, act_mis);
    end
    $display("single_drain: drained addr=%h", drained_addr[drained_addr.size() - 1]);
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i), ALU_SW, 1'b1, 32'h200, ALU_LW, 1'b1);
    checks++;
    if ({act_ready, act_stall, act_mis} !== 3'b100) begin
      errors++;
      $display("FAIL full_fill ready=%b stall=%b mis=%b required 1 0 0", act_ready, act_stall, act_mis);
    end
    drained_addr.delete();
    step(1'b1, 32'h310, 32'hDEADBEEF, ALU_SW, 1'b1, 32'h200, ALU_LW, 1'b1);
    checks++;
    if ({act_ready, act_stall, act_mis, act_maddr} !== {3'b011, 32'h300}) begin
      errors++;
      $display("FAIL full_force ready=%b stall=%b mis=%b addr=%h required 0 1 1 00000300",
               act_ready, act_stall, act_mis, act_maddr);
    end
    drain_idle("full");
    checks++;
    if (drained_addr.size() != 4) begin
      errors++;
      $display("FAIL full_count drained=%0d required 4", drained_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (drained_addr[i] !== 32'h300 + 32'(4 * i)) begin
          errors++;
          $display("FAIL full_order[%0d] addr=%h required %h", i, drained_addr[i], 32'h300 + 32'(4 * i));
        end
      end
    end
    $display("full: %0d entries drained in order", drained_addr.size());
  endtask

  task automatic test_fwd_word();
    step(1'b1, 32'h104, 32'hAABBCCDD, ALU_SW, 1'b0, 32'h0, 6'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 32'h104, ALU_LW, 1'b0);
`ifdef STORE_BUF_FWD_EN
    checks++;
    if ({act_fwd, act_stall, act_fwd_data} !== {2'b10, 32'hAABBCCDD}) begin
      errors++;
      $display("FAIL fwd_word fwd=%b stall=%b data=%h required 1 0 aabbccdd", act_fwd, act_stall, act_fwd_data);
    end
`else
    checks++;
    if ({act_stall, act_mis, act_fwd} !== 3'b110) begin
      errors++;
      $display("FAIL fwd_word_stall stall=%b mis=%b fwd=%b required 1 1 0", act_stall, act_mis, act_fwd);
    end
    step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 32'h104, ALU_LW, 1'b0);
`endif
    checks++;
    if ({ld_done, ld_result} !== {1'b1, 32'hAABBCCDD}) begin
      errors++;
      $display("FAIL fwd_word_result done=%b data=%h required 1 aabbccdd", ld_done, ld_result);
    end
    $display("fwd_word: load 0x104 -> %h", ld_result);
    drain_idle("fwd_word");
  endtask

  task automatic test_sb_stall();
    step(1'b1, 32'h109, 32'h0000007F, ALU_SB, 1'b0, 32'h0, 6'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 32'h108, ALU_LW, 1'b0);
    checks++;
    if ({act_stall, act_mis, act_maddr} !== {2'b11, 32'h109}) begin
      errors++;
      $display("FAIL sb_stall stall=%b mis=%b addr=%h required 1 1 00000109", act_stall, act_mis, act_maddr);
    end
    step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 32'h108, ALU_LW, 1'b0);
    checks++;
    if ({act_stall, ld_result} !== {1'b0, 32'h00007F00}) begin
      errors++;
      $display("FAIL sb_result stall=%b data=%h required 0 00007f00", act_stall, ld_result);
    end
    $display("sb_stall: load 0x108 -> %h", ld_result);
  endtask

  task automatic test_youngest();
    int n;
    step(1'b1, 32'h100, 32'h11223344, ALU_SW, 1'b1, 32'h200, ALU_LW, 1'b1);
    step(1'b1, 32'h100, 32'h55C3AA00, ALU_SW, 1'b1, 32'h200, ALU_LW, 1'b1);
    n = 0;
    step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 32'h102, ALU_LBU, 1'b0);
    while (!ld_done && n < 8) begin
      step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, 32'h102, ALU_LBU, 1'b0);
      n++;
    end
`ifdef STORE_BUF_FWD_EN
    checks++;
    if ({act_fwd, n} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL youngest_fwd fwd=%b stalled_cycles=%0d required 1 0", act_fwd, n);
    end
`endif
    checks++;
    if ({ld_done, ld_result} !== {1'b1, 32'h000000C3}) begin
      errors++;
      $display("FAIL youngest_data done=%b data=%h required 1 000000c3", ld_done, ld_result);
    end
    $display("youngest: LBU 0x102 -> %h after %0d stalls", ld_result, n);
    drain_idle("youngest");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h180 + 32'(4 * i), 32'h77000000 + 32'(i), ALU_SW, 1'b1, 32'h200, ALU_LW, 1'b1);
    @(negedge clk);
    allow_overlap = 1'b0;
    st_valid = 1'b0; ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({st_ready, empty, mem_is_store, ld_stall, fwd_valid, mem_addr} !== {5'b11000, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid flags=%b addr=%h required 11000 00000000",
               {st_ready, empty, mem_is_store, ld_stall, fwd_valid}, mem_addr);
    end
    model_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if ({act_mis, act_empty} !== 2'b01) begin
        errors++;
        $display("FAIL reset_mid_idle[%0d] mis=%b empty=%b required 0 1", i, act_mis, act_empty);
      end
    end
    checks++;
    if (dmem.exists(30'h60)) begin
      errors++;
      $display("FAIL reset_mid_mem word 0x180 written=%h required untouched", dmem[30'h60]);
    end
    $display("reset_mid: pending stores discarded");
  endtask

  task automatic test_random();
    logic [5:0]  scodes [3];
    logic [5:0]  lcodes [5];
    logic [31:0] sa, la, sd;
    logic [5:0]  sc, lc;
    int          op, bad;
    scodes = '{ALU_SB, ALU_SH, ALU_SW};
    lcodes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    bad = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      op = $urandom_range(0, 9);
      sc = scodes[$urandom_range(0, 2)];
      lc = lcodes[$urandom_range(0, 4)];
      sd = $urandom;
      sa = 32'h100 + 32'(4 * $urandom_range(0, 7));
      la = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if (sc == ALU_SB) sa = sa + 32'($urandom_range(0, 3));
      if (sc == ALU_SH) sa = sa + 32'(2 * $urandom_range(0, 1));
      if (lc == ALU_LB || lc == ALU_LBU) la = la + 32'($urandom_range(0, 3));
      if (lc == ALU_LH || lc == ALU_LHU) la = la + 32'(2 * $urandom_range(0, 1));
      if (op <= 3)      step(1'b1, sa, sd, sc, 1'b0, 32'h0, 6'h0, 1'b0);
      else if (op <= 6) step(1'b0, 32'h0, 32'h0, 6'h0, 1'b1, la, lc, 1'b0);
      else if (op == 7) step(1'b1, sa, sd, sc, 1'b1, la, lc, 1'b1);
      else              idle();
      checks++;
      if ({act_ready, act_empty, act_stall, act_fwd, act_mis} !== {exp_ready, exp_empty, exp_stall, exp_fwd, exp_mis}) begin
        errors++; bad++;
        $display("FAIL rand_flags cyc %0d got rdy/emp/stl/fwd/mis=%b required %b", cyc,
                 {act_ready, act_empty, act_stall, act_fwd, act_mis}, {exp_ready, exp_empty, exp_stall, exp_fwd, exp_mis});
      end
      checks++;
      if (act_fwd_data !== exp_fwd_data) begin
        errors++; bad++;
        $display("FAIL rand_fwd_data cyc %0d got %h required %h", cyc, act_fwd_data, exp_fwd_data);
      end
      checks++;
      if ({act_maddr, act_mdata, act_mcode} !== {exp_maddr, exp_mdata, exp_mcode}) begin
        errors++; bad++;
        $display("FAIL rand_head cyc %0d got %h/%h/%h required %h/%h/%h", cyc,
                 act_maddr, act_mdata, act_mcode, exp_maddr, exp_mdata, exp_mcode);
      end
    end
    drain_idle("random");
    $display("random: 400 cycles, %0d mismatching cycles", bad);
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_full();
    test_fwd_word();
    test_sb_stall();
    test_youngest();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
